// File: rtl/sensor_interval_timer_pkg.sv
// Shared types and default constants for sensor_interval_timer.
//   state_e        : FSM state encoding (ST_IDLE, ST_TIMING)
//   TICK_DIV_DEF   : default clock cycles per tick (1 ms at 50 MHz)
//   CNT_W_DEF      : default interval counter / time_out width
//   MAX_TICKS_DEF  : default tick count that aborts a measurement
package sensor_interval_timer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_TIMING = 1'b1
  } state_e;

  localparam int TICK_DIV_DEF  = 50000;
  localparam int CNT_W_DEF     = 19;
  localparam int MAX_TICKS_DEF = (1 << 19) - 1;

endpackage

// File: rtl/sensor_interval_timer_if.sv
// Sensor / result bundle between the track-sensor side and the timer.
//   s1, s2   : sensor levels (high = train present)
//   time_out : last completed interval in ticks
//   valid    : one-cycle strobe when time_out updates
//   busy     : measurement in progress
//   timeout  : one-cycle strobe when a measurement is aborted
// master = sensor/consumer side, slave = timer.
interface sensor_interval_timer_if
  import sensor_interval_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] time_out;
  logic             valid;
  logic             busy;
  logic             timeout;

  modport master (output s1, s2, input  time_out, valid, busy, timeout);
  modport slave  (input  s1, s2, output time_out, valid, busy, timeout);
endinterface

// File: rtl/sensor_interval_timer_tick_prescaler.sv
// tick_prescaler: modulo-TICK_DIV cycle counter.
//   clk, rst : clock, async active-high reset
//   clear    : restart the count at 0 (wins over enable)
//   enable   : count this cycle
//   tick     : one-cycle pulse in the cycle the count sits at TICK_DIV-1
//              while enabled (the count wraps on that edge)
module tick_prescaler
  import sensor_interval_timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/sensor_interval_timer.sv
// sensor_interval_timer: ticks elapsed from an s1 rise to the next s2 rise.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of sensor_interval_timer_if (s1/s2 in;
//              time_out/valid/busy/timeout out, all registered)
// Optional: define INPUT_SYNC_EN to put a 2-flop synchronizer on s1/s2
// ahead of edge detection (start and stop both shift by 2 cycles).
module sensor_interval_timer
  import sensor_interval_timer_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_TICKS = MAX_TICKS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  sensor_interval_timer_if.slave  bus
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_TICKS);

  logic s1_in, s2_in;

`ifdef INPUT_SYNC_EN
  logic [1:0] s1_sync, s2_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sync <= '0;
      s2_sync <= '0;
    end else begin
      s1_sync <= {s1_sync[0], bus.s1};
      s2_sync <= {s2_sync[0], bus.s2};
    end
  end
  assign s1_in = s1_sync[1];
  assign s2_in = s2_sync[1];
`else
  assign s1_in = bus.s1;
  assign s2_in = bus.s2;
`endif

  // Edge flops reset low, so a sensor held high through reset release
  // reads as a rise on the first clock.
  logic s1_q, s2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_in;
      s2_q <= s2_in;
    end
  end

  logic s1_rise, s2_rise;
  assign s1_rise = s1_in & ~s1_q;
  assign s2_rise = s2_in & ~s2_q;

  state_e           state, state_n;
  logic             start, done, abort;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic             at_max;
  logic [CNT_W-1:0] result;

  assign at_max = (cnt == MAX_C);

  // A tick landing on the stop edge belongs to the interval, so it is
  // folded into the reported value; at MAX_TICKS it saturates instead.
  assign result = (tick && !at_max) ? cnt + 1'b1 : cnt;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (state == ST_TIMING),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      ST_IDLE: begin
        // A coincident s2 rise is deliberately dropped here.
        if (s1_rise) begin
          start   = 1'b1;
          state_n = ST_TIMING;
        end
      end
      ST_TIMING: begin
        // s2 is checked first so it beats a coincident timeout tick.
        if (s2_rise) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end else if (tick && at_max) begin
          abort   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Counter stops at MAX_TICKS; the timeout leaves TIMING before any wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cnt <= '0;
    else if (start)                                   cnt <= '0;
    else if (state == ST_TIMING && tick && !at_max)   cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.time_out <= '0;
      bus.valid    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.timeout  <= 1'b0;
    end else begin
      bus.valid   <= done;
      bus.timeout <= abort;
      bus.busy    <= (state_n == ST_TIMING);
      if (done) bus.time_out <= result;
    end
  end
endmodule

// File: tb/tb_sensor_interval_timer.sv
// Randomized self-checking bench for sensor_interval_timer
// (TICK_DIV=4, MAX_TICKS=20). Expected results come from an interval
// model: floor(distance / TICK_DIV), saturating at MAX_TICKS on the exact
// timeout edge, timeout beyond it.
module tb_sensor_interval_timer;
  import sensor_interval_timer_pkg::*;

  localparam int TD   = 4;
  localparam int MAXT = 20;
  localparam int W    = 19;
  localparam int T    = (MAXT + 1) * TD;  // distance at which timeout fires
`ifdef INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sensor_interval_timer_if #(.CNT_W(W)) bus ();

  sensor_interval_timer #(.TICK_DIV(TD), .CNT_W(W), .MAX_TICKS(MAXT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [W-1:0] exp_time = '0;

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_val(input int d);
    return (d < T) ? d / TD : MAXT;
  endfunction

  // s1 rise sampled at window edge 0, s2 rise at edge d. Optional extra s1
  // rise at d/2 (mid) and an s2 rise coincident with the start (sim).
  task automatic do_meas(input int d, input bit mid, input bit sim, input string tag);
    int nv = 0, vk = -1, nt = 0, tk = -1, nb = 0;
    logic [W-1:0] vv = '0;
    bit exp_valid;
    exp_valid = (d <= T);
    for (int k = 0; k <= d + LAT; k++) begin
      bus.s1 = (k == 0) || (mid && k == d / 2);
      bus.s2 = (k == d) || (sim && k == 0);
      tick1();
      if (bus.valid)   begin nv++; vk = k; vv = bus.time_out; end
      if (bus.timeout) begin nt++; tk = k; end
      if (bus.busy)    nb++;
    end
    bus.s1 = 1'b0;
    bus.s2 = 1'b0;
    if (exp_valid) exp_time = W'(model_val(d));

    checks++;
    if (nv !== (exp_valid ? 1 : 0)) begin
      failures++;
      $display("FAIL %s valid_count d=%0d got=%0d exp=%0d", tag, d, nv, exp_valid ? 1 : 0);
    end
    checks++;
    if (nt !== (exp_valid ? 0 : 1)) begin
      failures++;
      $display("FAIL %s timeout_count d=%0d got=%0d exp=%0d", tag, d, nt, exp_valid ? 0 : 1);
    end
    if (exp_valid) begin
      checks++;
      if (vk !== d + LAT) begin
        failures++;
        $display("FAIL %s valid_cycle d=%0d got=%0d exp=%0d", tag, d, vk, d + LAT);
      end
      checks++;
      if (vv !== exp_time) begin
        failures++;
        $display("FAIL %s value d=%0d got=%0d exp=%0d", tag, d, vv, exp_time);
      end
    end else begin
      checks++;
      if (tk !== T + LAT) begin
        failures++;
        $display("FAIL %s timeout_cycle d=%0d got=%0d exp=%0d", tag, d, tk, T + LAT);
      end
    end
    checks++;
    if (nb !== (exp_valid ? d : T)) begin
      failures++;
      $display("FAIL %s busy_cycles d=%0d got=%0d exp=%0d", tag, d, nb, exp_valid ? d : T);
    end
    checks++;
    if (bus.time_out !== exp_time) begin
      failures++;
      $display("FAIL %s held_time_out d=%0d got=%0d exp=%0d", tag, d, bus.time_out, exp_time);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s1 = 1'b0;
    bus.s2 = 1'b0;
    tick1();
    tick1();
    checks++;
    if (bus.time_out !== '0) begin failures++; $display("FAIL reset time_out got=%0d exp=0", bus.time_out); end
    checks++;
    if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset valid got=%b exp=0", bus.valid); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset timeout got=%b exp=0", bus.timeout); end
    rst = 1'b0;
    tick1();
    tick1();
  endtask

  task automatic test_basic();
    do_meas(40, 1'b0, 1'b0, "basic");
    checks++;
    if (bus.time_out !== 19'd10) begin
      failures++;
      $display("FAIL basic_known time_out got=%0d exp=10", bus.time_out);
    end
    tick1();
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL basic valid_width got=%b exp=0", bus.valid);
    end
  endtask

  task automatic test_ignored_s2();
    int nv = 0, nb = 0;
    tick1();
    bus.s2 = 1'b1;
    tick1();
    bus.s2 = 1'b0;
    for (int k = 0; k < 6 + LAT; k++) begin
      tick1();
      if (bus.valid) nv++;
      if (bus.busy)  nb++;
    end
    checks++;
    if (nv !== 0) begin failures++; $display("FAIL idle_s2 valid_count got=%0d exp=0", nv); end
    checks++;
    if (nb !== 0) begin failures++; $display("FAIL idle_s2 busy_cycles got=%0d exp=0", nb); end
  endtask

  task automatic test_mid_s1();
    tick1();
    do_meas(30, 1'b1, 1'b0, "mid_s1");
  endtask

  task automatic test_timeout();
    tick1();
    do_meas(90, 1'b0, 1'b0, "timeout");
  endtask

  task automatic test_reset_mid();
    tick1();
    bus.s1 = 1'b1;
    tick1();
    bus.s1 = 1'b0;
    repeat (10) tick1();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_mid busy_before got=%b exp=1", bus.busy); end
    #3 rst = 1'b1;
    #1;
    exp_time = '0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.time_out !== '0) begin failures++; $display("FAIL rst_mid time_out got=%0d exp=0", bus.time_out); end
    checks++;
    if (bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid strobes got=%b%b exp=00", bus.valid, bus.timeout);
    end
    // sensor held high across release counts as a rise
    bus.s1 = 1'b1;
    tick1();
    rst = 1'b0;
    repeat (1 + LAT) tick1();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_release_high busy got=%b exp=1", bus.busy); end
    rst = 1'b1;
    bus.s1 = 1'b0;
    tick1();
    rst = 1'b0;
    tick1();
    do_meas(12, 1'b0, 1'b0, "rst_then_meas");
  endtask

  task automatic test_simultaneous();
    tick1();
    tick1();
    do_meas(8, 1'b0, 1'b1, "simul");
    do_meas(10, 1'b0, 1'b0, "back_to_back1");
    do_meas(21, 1'b0, 1'b0, "back_to_back2");
  endtask

  task automatic test_boundary();
    tick1();
    do_meas(T, 1'b0, 1'b0, "bnd_timeout_edge");
    do_meas(T - 1, 1'b0, 1'b0, "bnd_below_timeout");
    do_meas(TD - 1, 1'b0, 1'b0, "bnd_sub_tick");
    do_meas(TD, 1'b0, 1'b0, "bnd_one_tick");
    do_meas(1, 1'b0, 1'b0, "bnd_one_cycle");
    tick1();
    do_meas(T + 1, 1'b0, 1'b0, "bnd_past_timeout");
  endtask

  task automatic test_random();
    int d, gap;
    bit mid;
    for (int i = 0; i < 14; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick1();
      d   = $urandom_range(1, 95);
      mid = (d >= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_meas(d, mid, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored_s2();
    test_mid_s1();
    test_timeout();
    test_reset_mid();
    test_simultaneous();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
